int_compare_reduce: RTL and testbench
=====================================

// Module: int_compare_reduce
// PURPOSE
// - Versat functional unit: configurable integer comparator. Successor to the single-op greater-than unit.
// - Adds six compare ops, signed/unsigned mode, element-wise select, and a streaming reduction
//   (running extreme plus its index), with a programmable pipeline latency.
// - Sits in the Versat datapath; in0/in1 come from the crossbar, out0/out1 go back to it.
// PARAMETERS
// - DATA_W   32  operand/result width (>=2)
// - LATENCY  1   cycles from input sample to out0/out1 (1..4); exported as versat_latency
// - CNT_W    16  width of sample index / true-count (<=DATA_W), zero-extended onto out1
// PORTS
// - clk        in   1       clock
// - rst        in   1       reset: asynchronous, active-high
// - running    in   1       accelerator active; in0/in1 valid every cycle it is high
// - run        in   1       one-cycle start pulse; latches config, clears state
// - op         in   3       0 GT, 1 GE, 2 LT, 3 LE, 4 EQ, 5 NE, 6/7 -> result always 0
// - signed_en  in   1       1: two's-complement compare; 0: unsigned
// - mode       in   2       0 MASK, 1 SELECT, 2 REDUCE, 3 COUNT
// - in0        in   DATA_W  operand A
// - in1        in   DATA_W  operand B
// - out0       out  DATA_W  result, LATENCY cycles after the sample (versat_latency = LATENCY)
// - out1       out  DATA_W  count/index side result, same latency
// BEHAVIOUR
// - Reset (async): out0=0, out1=0, all pipeline/acc/counter regs=0. Config regs: op=GT, signed_en=0, mode=MASK.
// - Config: op/signed_en/mode are sampled only on the run cycle and held until the next run.
// - Run cycle: clears acc, first-flag, sample index and true-count. Not a sample.
//   run takes priority over running in the same cycle.
// - Sample cycle: running=1 and run=0. The index increments after each sample; first sample has index 0.
// - c = op(in0,in1) using latched config. Ops 6/7 give c=0. GE/LE/EQ are true on equality.
// - Outputs per sample, before the delay line:
//   - MASK:   out0={DATA_W{c}};      out1=true-count incl. this sample
//   - SELECT: out0=c ? in0 : in1;    out1=true-count incl. this sample
//   - REDUCE: first sample loads acc=in0, idx=0; later samples load acc=in0, idx=index
//     only if op(in0,acc) is true. out0=acc, out1=idx after update.
//     Ties: GT/LT keep the first occurrence; GE/LE take the last.
//   - COUNT:  out0={{DATA_W-1{0}},c}; out1=true-count incl. this sample
// - true-count and index saturate at 2^CNT_W-1 and do not wrap.
// - Stage 1 registers the per-mode result. LATENCY-1 further plain registers follow. Total = LATENCY cycles.
// - Non-sample cycles (running=0):
//   - acc/count/index are held.
//   - The stage-1 register recomputes from current inputs in MASK/SELECT/COUNT (the compare is free-running).
//   - In REDUCE, stage 1 holds acc/idx.
// - run pulse: clears state in the next cycle. Outputs in flight keep shifting.
//   The first post-run result appears LATENCY cycles after the first sample.
// - rst mid-operation: all state cleared immediately. Operation resumes only after a new run.
// - Signed compare: flip the MSB of both operands and compare unsigned. No width extension needed.
// STRUCTURE
// - Header int_cmp_defs.vh: localparams OP_GT..OP_NE, MODE_MASK/SELECT/REDUCE/COUNT, default config values.
// - Sub-module int_cmp_core (combinational): (a, b, op, signed_en) -> c.
//   Instantiated twice: in0-vs-in1, and in0-vs-acc for REDUCE.
// - Top level holds: config regs, index/count counters, acc/idx regs, result mux,
//   and the delay line (generate loop over LATENCY-1).
// TESTING
// 1. MASK, GT, unsigned, LATENCY=1: in0=5, in1=3 -> out0=0xFFFFFFFF one cycle later.
//    in0=3, in1=5 -> out0=0. out1 counts 1, then 1.
// 2. Signed LT: in0=0xFFFFFFFF, in1=1.
//    signed_en=1 -> out0=all ones; signed_en=0 (new run) -> out0=0.
// 3. SELECT, GT: (7,9), (12,4), (-1,0) unsigned -> out0 = 9, 12, 0xFFFFFFFF.
//    Same stream with LT -> 7, 4, 0.
// 4. REDUCE on in0 stream 4,9,2,9,1:
//    GT -> final out0=9, out1=1. GE -> out0=9, out1=3. LT signed -> out0=1, out1=4.
// 5. COUNT, EQ: pairs (1,1), (2,3), (5,5), (0,0), (7,8), (6,9) -> out1=3, out0 bit0 = 1,0,1,1,0,0.
//    A run pulse mid-stream restarts out1 from 0. CNT_W=2 saturates at 3.
// 6. LATENCY=3, REDUCE: assert rst mid-stream -> out0=out1=0 immediately and config=MASK/GT.
//    After a new run, the first result appears exactly 3 cycles after the first sample.

Source files
------------

// File: rtl/int_compare_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_compare_reduce_pkg
// Description : Shared opcodes, output modes and reset-default configuration
//               for the int_compare_reduce Versat functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
package int_compare_reduce_pkg;

   // Comparison opcodes; codes 6 and 7 are legal and always compare false.
   localparam logic [2:0] OP_GT = 3'd0;
   localparam logic [2:0] OP_GE = 3'd1;
   localparam logic [2:0] OP_LT = 3'd2;
   localparam logic [2:0] OP_LE = 3'd3;
   localparam logic [2:0] OP_EQ = 3'd4;
   localparam logic [2:0] OP_NE = 3'd5;

   // Output selection modes.
   typedef enum logic [1:0] {
      MODE_MASK   = 2'd0,
      MODE_SELECT = 2'd1,
      MODE_REDUCE = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

   // Configuration held after reset until the first run pulse.
   localparam logic [2:0] DEFAULT_OP        = OP_GT;
   localparam logic       DEFAULT_SIGNED_EN = 1'b0;
   localparam mode_e      DEFAULT_MODE      = MODE_MASK;

endpackage : int_compare_reduce_pkg
`default_nettype wire

// File: rtl/int_compare_reduce_core.sv
`default_nettype none
// ============================================================================
// Module      : int_compare_reduce_core
// Description : Combinational integer comparator. Signed mode flips the MSB
//               of both operands so that one unsigned comparator serves both.
// Revision    : 1.0 - initial release
// ============================================================================
module int_compare_reduce_core
   import int_compare_reduce_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [2:0]        i_op,
   input  logic              i_signed_en,
   output logic              o_c
);

   logic [DATA_W-1:0] w_flip;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;

   assign w_flip = {i_signed_en, {(DATA_W-1){1'b0}}};
   assign w_a    = i_a ^ w_flip;
   assign w_b    = i_b ^ w_flip;

   // Evaluate the selected relation on the (possibly MSB-flipped) operands.
   always_comb begin
      o_c = 1'b0;
      case (i_op)
         OP_GT:   o_c = (w_a >  w_b);
         OP_GE:   o_c = (w_a >= w_b);
         OP_LT:   o_c = (w_a <  w_b);
         OP_LE:   o_c = (w_a <= w_b);
         OP_EQ:   o_c = (w_a == w_b);
         OP_NE:   o_c = (w_a != w_b);
         default: o_c = 1'b0;
      endcase
   end

endmodule : int_compare_reduce_core
`default_nettype wire

// File: rtl/int_compare_reduce.sv
`default_nettype none
// ============================================================================
// Module      : int_compare_reduce
// Description : Versat configurable integer comparator with mask, select,
//               streaming reduction (extreme value plus index) and count
//               modes, followed by a LATENCY-deep output delay line.
// Revision    : 1.0 - initial release
// ============================================================================
module int_compare_reduce
   import int_compare_reduce_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              running,
   input  logic              run,
   input  logic [2:0]        op,
   input  logic              signed_en,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1
);

   // Latency seen by the Versat scheduler.
   localparam int versat_latency = LATENCY;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   // Latched configuration
   logic [2:0]        r_op;
   logic              r_signed_en;
   mode_e             r_mode;

   // Streaming state. r_armed is set by the first run after reset so that
   // nothing accumulates until the host has configured the unit.
   logic              r_armed;
   logic              r_have;
   logic [DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_index;
   logic [CNT_W-1:0]  r_count;

   // Stage-1 registers
   logic [DATA_W-1:0] r_s1_out0;
   logic [DATA_W-1:0] r_s1_out1;

   logic              w_sample;
   logic              w_c;
   logic              w_c_acc;
   logic              w_upd;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [CNT_W-1:0]  w_index_nxt;
   logic [CNT_W-1:0]  w_cnt_view;
   logic [DATA_W-1:0] w_acc_nxt;
   logic [CNT_W-1:0]  w_idx_nxt;
   logic [DATA_W-1:0] w_s0;
   logic [DATA_W-1:0] w_s1;

   // run wins over running, so a run cycle is never a sample.
   assign w_sample = running & ~run & r_armed;

   // Element-wise compare: in0 against in1.
   int_compare_reduce_core #(
      .DATA_W (DATA_W)
   ) u_cmp_elem (
      .i_a         (in0),
      .i_b         (in1),
      .i_op        (r_op),
      .i_signed_en (r_signed_en),
      .o_c         (w_c)
   );

   // Reduction compare: in0 against the running extreme.
   int_compare_reduce_core #(
      .DATA_W (DATA_W)
   ) u_cmp_acc (
      .i_a         (in0),
      .i_b         (r_acc),
      .i_op        (r_op),
      .i_signed_en (r_signed_en),
      .o_c         (w_c_acc)
   );

   // Saturating counters: never wrap once all ones.
   assign w_count_nxt = (w_c && (r_count != c_cnt_max)) ? r_count + CNT_W'(1) : r_count;
   assign w_index_nxt = (r_index != c_cnt_max) ? r_index + CNT_W'(1) : r_index;
   assign w_cnt_view  = w_sample ? w_count_nxt : r_count;

   // The first sample always loads; afterwards strict ops keep the first
   // occurrence of a tie and inclusive ops take the latest one.
   assign w_upd     = ~r_have | w_c_acc;
   assign w_acc_nxt = w_upd ? in0 : r_acc;
   assign w_idx_nxt = w_upd ? r_index : r_idx;

   // Per-mode result ahead of the delay line.
   always_comb begin
      w_s0 = {DATA_W{w_c}};
      w_s1 = DATA_W'(w_cnt_view);
      case (r_mode)
         MODE_MASK: begin
            w_s0 = {DATA_W{w_c}};
            w_s1 = DATA_W'(w_cnt_view);
         end
         MODE_SELECT: begin
            w_s0 = w_c ? in0 : in1;
            w_s1 = DATA_W'(w_cnt_view);
         end
         MODE_REDUCE: begin
            w_s0 = w_sample ? w_acc_nxt : r_acc;
            w_s1 = w_sample ? DATA_W'(w_idx_nxt) : DATA_W'(r_idx);
         end
         MODE_COUNT: begin
            w_s0 = DATA_W'(w_c);
            w_s1 = DATA_W'(w_cnt_view);
         end
         default: begin
            w_s0 = '0;
            w_s1 = '0;
         end
      endcase
   end

   // Configuration latch and streaming state; run clears, samples advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op        <= DEFAULT_OP;
         r_signed_en <= DEFAULT_SIGNED_EN;
         r_mode      <= DEFAULT_MODE;
         r_armed     <= 1'b0;
         r_have      <= 1'b0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_index     <= '0;
         r_count     <= '0;
      end else if (run) begin
         r_op        <= op;
         r_signed_en <= signed_en;
         r_mode      <= mode_e'(mode);
         r_armed     <= 1'b1;
         r_have      <= 1'b0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_index     <= '0;
         r_count     <= '0;
      end else if (w_sample) begin
         r_count <= w_count_nxt;
         r_index <= w_index_nxt;
         if (r_mode == MODE_REDUCE) begin
            r_acc  <= w_acc_nxt;
            r_idx  <= w_idx_nxt;
            r_have <= 1'b1;
         end
      end
   end

   // Stage 1: register the per-mode result every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_out0 <= '0;
         r_s1_out1 <= '0;
      end else begin
         r_s1_out0 <= w_s0;
         r_s1_out1 <= w_s1;
      end
   end

   // Delay line: element 0 is stage 1, each further element adds one cycle.
   logic [DATA_W-1:0] w_chain0 [versat_latency];
   logic [DATA_W-1:0] w_chain1 [versat_latency];

   assign w_chain0[0] = r_s1_out0;
   assign w_chain1[0] = r_s1_out1;

   for (genvar i = 1; i < versat_latency; i++) begin : g_delay
      logic [DATA_W-1:0] r_q0;
      logic [DATA_W-1:0] r_q1;

      // One plain pipeline register per extra cycle of latency.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_q0 <= '0;
            r_q1 <= '0;
         end else begin
            r_q0 <= w_chain0[i-1];
            r_q1 <= w_chain1[i-1];
         end
      end

      assign w_chain0[i] = r_q0;
      assign w_chain1[i] = r_q1;
   end

   assign out0 = w_chain0[versat_latency-1];
   assign out1 = w_chain1[versat_latency-1];

endmodule : int_compare_reduce
`default_nettype wire

// File: tb/tb_int_compare_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_compare_reduce
// Description : Directed self-checking bench for int_compare_reduce. Three
//               instances share stimulus: LATENCY=1/CNT_W=16, LATENCY=1/
//               CNT_W=2 (saturation) and LATENCY=3/CNT_W=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_compare_reduce;
   import int_compare_reduce_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        running = 1'b0;
   logic        run = 1'b0;
   logic [2:0]  op = 3'd0;
   logic        signed_en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [31:0] in0 = '0;
   logic [31:0] in1 = '0;

   logic [31:0] a_out0, a_out1;
   logic [31:0] b_out0, b_out1;
   logic [31:0] c_out0, c_out1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   int_compare_reduce #(.DATA_W(32), .LATENCY(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .running(running), .run(run), .op(op),
      .signed_en(signed_en), .mode(mode), .in0(in0), .in1(in1),
      .out0(a_out0), .out1(a_out1));

   int_compare_reduce #(.DATA_W(32), .LATENCY(1), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .running(running), .run(run), .op(op),
      .signed_en(signed_en), .mode(mode), .in0(in0), .in1(in1),
      .out0(b_out0), .out1(b_out1));

   int_compare_reduce #(.DATA_W(32), .LATENCY(3), .CNT_W(16)) u_c (
      .clk(clk), .rst(rst), .running(running), .run(run), .op(op),
      .signed_en(signed_en), .mode(mode), .in0(in0), .in1(in1),
      .out0(c_out0), .out1(c_out1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run pulse with running held high, so a wrongly counted run would show.
   task automatic do_run(input logic [2:0] o, input logic s, input mode_e m);
      op = o; signed_en = s; mode = m;
      run = 1'b1; running = 1'b1; in0 = 32'd9; in1 = 32'd9;
      tick();
      run = 1'b0; running = 1'b0;
   endtask

   task automatic sample(input logic [31:0] a, input logic [31:0] b);
      running = 1'b1; in0 = a; in1 = b;
      tick();
      running = 1'b0;
   endtask

   task automatic idle(input logic [31:0] a, input logic [31:0] b);
      running = 1'b0; in0 = a; in1 = b;
      tick();
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      #1;
      check("rst_out0", a_out0, 32'h0);
      check("rst_out1", a_out1, 32'h0);
      check("rst_l3_out0", c_out0, 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // 1. MASK GT unsigned
      do_run(OP_GT, 1'b0, MODE_MASK);
      sample(32'd5, 32'd3);
      check("mask_gt_true_out0", a_out0, 32'hFFFF_FFFF);
      check("mask_gt_true_out1", a_out1, 32'd1);
      sample(32'd3, 32'd5);
      check("mask_gt_false_out0", a_out0, 32'h0);
      check("mask_gt_false_out1", a_out1, 32'd1);
      idle(32'd5, 32'd3);
      check("mask_idle_free_out0", a_out0, 32'hFFFF_FFFF);
      check("mask_idle_held_out1", a_out1, 32'd1);

      // 2. Signed versus unsigned LT
      do_run(OP_LT, 1'b1, MODE_MASK);
      sample(32'hFFFF_FFFF, 32'd1);
      check("lt_signed_out0", a_out0, 32'hFFFF_FFFF);
      do_run(OP_LT, 1'b0, MODE_MASK);
      sample(32'hFFFF_FFFF, 32'd1);
      check("lt_unsigned_out0", a_out0, 32'h0);

      // 3. SELECT
      do_run(OP_GT, 1'b0, MODE_SELECT);
      sample(32'd7, 32'd9);
      check("sel_gt_0", a_out0, 32'd9);
      sample(32'd12, 32'd4);
      check("sel_gt_1", a_out0, 32'd12);
      sample(32'hFFFF_FFFF, 32'd0);
      check("sel_gt_2", a_out0, 32'hFFFF_FFFF);
      check("sel_gt_cnt", a_out1, 32'd2);
      do_run(OP_LT, 1'b0, MODE_SELECT);
      sample(32'd7, 32'd9);
      check("sel_lt_0", a_out0, 32'd7);
      sample(32'd12, 32'd4);
      check("sel_lt_1", a_out0, 32'd4);
      sample(32'hFFFF_FFFF, 32'd0);
      check("sel_lt_2", a_out0, 32'd0);
      check("sel_lt_cnt", a_out1, 32'd1);

      // 4. REDUCE on 4,9,2,9,1
      do_run(OP_GT, 1'b0, MODE_REDUCE);
      sample(32'd4, 32'd0);
      check("red_gt_first_out0", a_out0, 32'd4);
      check("red_gt_first_out1", a_out1, 32'd0);
      sample(32'd9, 32'd0);
      sample(32'd2, 32'd0);
      sample(32'd9, 32'd0);
      sample(32'd1, 32'd0);
      check("red_gt_out0", a_out0, 32'd9);
      check("red_gt_out1", a_out1, 32'd1);
      idle(32'd100, 32'd0);
      check("red_idle_hold_out0", a_out0, 32'd9);
      check("red_idle_hold_out1", a_out1, 32'd1);

      do_run(OP_GE, 1'b0, MODE_REDUCE);
      sample(32'd4, 32'd0);
      sample(32'd9, 32'd0);
      sample(32'd2, 32'd0);
      sample(32'd9, 32'd0);
      sample(32'd1, 32'd0);
      check("red_ge_out0", a_out0, 32'd9);
      check("red_ge_out1", a_out1, 32'd3);

      do_run(OP_LT, 1'b1, MODE_REDUCE);
      sample(32'd4, 32'd0);
      sample(32'd9, 32'd0);
      sample(32'd2, 32'd0);
      sample(32'd9, 32'd0);
      sample(32'd1, 32'd0);
      check("red_lt_out0", a_out0, 32'd1);
      check("red_lt_out1", a_out1, 32'd4);

      // 5. COUNT EQ
      do_run(OP_EQ, 1'b0, MODE_COUNT);
      sample(32'd1, 32'd1);
      check("cnt_b0_0", a_out0, 32'd1);
      sample(32'd2, 32'd3);
      check("cnt_b0_1", a_out0, 32'd0);
      sample(32'd5, 32'd5);
      check("cnt_b0_2", a_out0, 32'd1);
      sample(32'd0, 32'd0);
      check("cnt_b0_3", a_out0, 32'd1);
      check("cnt_sat_at3", b_out1, 32'd3);
      sample(32'd7, 32'd8);
      check("cnt_b0_4", a_out0, 32'd0);
      sample(32'd6, 32'd9);
      check("cnt_b0_5", a_out0, 32'd0);
      check("cnt_total", a_out1, 32'd3);
      sample(32'd6, 32'd6);
      check("cnt_wide_4", a_out1, 32'd4);
      check("cnt_sat_hold", b_out1, 32'd3);
      do_run(OP_EQ, 1'b0, MODE_COUNT);
      sample(32'd2, 32'd2);
      check("cnt_restart", a_out1, 32'd1);
      sample(32'd2, 32'd3);
      check("cnt_restart_hold", a_out1, 32'd1);

      // 6. LATENCY=3, reset mid-stream, then first-result latency
      do_run(OP_GT, 1'b0, MODE_REDUCE);
      sample(32'd4, 32'd0);
      sample(32'd9, 32'd0);
      sample(32'd2, 32'd0);
      check("l3_pre_rst_out0", c_out0, 32'd4);
      rst = 1'b1;
      #1;
      check("l3_rst_out0", c_out0, 32'h0);
      check("l3_rst_out1", c_out1, 32'h0);
      tick();
      rst = 1'b0;
      sample(32'd5, 32'd3);
      sample(32'd5, 32'd3);
      sample(32'd5, 32'd3);
      check("l3_cfg_mask_gt_out0", c_out0, 32'hFFFF_FFFF);
      check("l3_cfg_no_count_out1", c_out1, 32'h0);
      idle(32'd0, 32'd0);
      idle(32'd0, 32'd0);
      op = OP_GT; signed_en = 1'b0; mode = MODE_REDUCE;
      run = 1'b1; running = 1'b0; in0 = 32'd0; in1 = 32'd0;
      tick();
      run = 1'b0;
      sample(32'd4, 32'd0);
      check("l3_lat_c1", c_out0, 32'h0);
      idle(32'd0, 32'd0);
      check("l3_lat_c2", c_out0, 32'h0);
      idle(32'd0, 32'd0);
      check("l3_lat_c3_out0", c_out0, 32'd4);
      check("l3_lat_c3_out1", c_out1, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_int_compare_reduce
`default_nettype wire
